// File: rtl/sort_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_mem_responder_if
// Description : Avalon-MM slave bus bundle for the sort memory responder.
//               The master modport is used by whatever drives requests (the
//               sorter or a testbench). The slave modport is used by the
//               responder itself.
//   slave_address   : byte address
//   slave_read      : read request
//   slave_readdata  : registered read data, returned one cycle after the read
//   slave_write     : write request
//   slave_writedata : write data
// Revision    : 1.0  initial release
// ============================================================================
interface sort_mem_responder_if;
  logic [31:0] slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;

  modport master (
    output slave_address,
    output slave_read,
    output slave_write,
    output slave_writedata,
    input  slave_readdata
  );

  modport slave (
    input  slave_address,
    input  slave_read,
    input  slave_write,
    input  slave_writedata,
    output slave_readdata
  );
endinterface
`default_nettype wire

// File: rtl/sort_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sort_mem_responder
// Description : Avalon-MM word memory (2^DEPTH_LOG2 x 32) for the sorting
//               accelerator. It has no wait states and returns read data one
//               cycle after the request. A built-in checker scans the array
//               and reports whether the contents are non-decreasing
//               (unsigned). It also reports the first out-of-order index.
//   clk              : single clock, all logic on posedge
//   rst              : synchronous active-high reset (array not cleared)
//   bus              : Avalon-MM slave bundle (sort_mem_responder_if.slave)
//   check_start      : start an order check (only accepted when idle)
//   check_busy       : check in progress
//   check_done       : result valid (level, held until next start / rst)
//   check_sorted     : 1 = array non-decreasing
//   check_fail_index : lower index k of first pair with mem[k] > mem[k+1]
//   access_error     : sticky illegal-access flag, cleared only by rst
// Revision    : 1.0  initial release
// ============================================================================
module sort_mem_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  sort_mem_responder_if.slave   bus,
  input  logic                  check_start,
  output logic                  check_busy,
  output logic                  check_done,
  output logic                  check_sorted,
  output logic [DEPTH_LOG2-1:0] check_fail_index,
  output logic                  access_error
);

  localparam int                    C_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] C_LAST_IDX = '1;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_FETCH0 = 2'd1,
    C_SCAN   = 2'd2,
    C_DONE   = 2'd3
  } chk_state_t;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic                  w_legal;
  logic [DEPTH_LOG2-1:0] w_bus_idx;
  logic                  w_bus_active;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_rd_zero;
  logic                  w_err;

  // Out-of-range addresses never alias: every bit above the index must be 0.
  assign w_legal      = (bus.slave_address[1:0] == 2'b00) &&
                        (bus.slave_address[31:DEPTH_LOG2+2] == '0);
  assign w_bus_idx    = bus.slave_address[DEPTH_LOG2+1:2];
  assign w_bus_active = bus.slave_read | bus.slave_write;
  assign w_wr_en      = bus.slave_write & w_legal;
  // A read that collides with a write is ignored, so readdata holds.
  assign w_rd_en      = bus.slave_read & ~bus.slave_write & w_legal;
  assign w_rd_zero    = bus.slave_read & ~bus.slave_write & ~w_legal;
  assign w_err        = (w_bus_active & ~w_legal) |
                        (bus.slave_read & bus.slave_write);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]           r_mem [C_DEPTH];
  logic [31:0]           r_chk_word;
  logic                  w_chk_issue;
  logic [DEPTH_LOG2-1:0] w_chk_rd_idx;

  // The checker has its own data register. A bus stall therefore leaves the
  // in-flight word intact, and each stall costs exactly one cycle.
  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_bus_idx] <= bus.slave_writedata;
    end
    if (w_chk_issue) begin
      r_chk_word <= r_mem[w_chk_rd_idx];
    end
  end

  logic [31:0] r_readdata;
  logic        r_access_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_readdata     <= '0;
      r_access_error <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_readdata <= r_mem[w_bus_idx];
      end else if (w_rd_zero) begin
        r_readdata <= '0;
      end
      if (w_err) begin
        r_access_error <= 1'b1;
      end
    end
  end

  assign bus.slave_readdata = r_readdata;
  assign access_error       = r_access_error;

  // --------------------------------------------------------------------------
  // Order checker
  // --------------------------------------------------------------------------
  chk_state_t            r_state;
  chk_state_t            w_state_next;
  logic [DEPTH_LOG2-1:0] r_idx;       // index of the word arriving in C_SCAN
  logic [DEPTH_LOG2-1:0] w_idx_next;
  logic [31:0]           r_prev;
  logic                  w_prev_load;
  logic                  w_clear;
  logic                  w_result_set;
  logic                  w_result_sorted;
  logic [DEPTH_LOG2-1:0] w_result_idx;
  logic                  r_done;
  logic                  r_sorted;
  logic [DEPTH_LOG2-1:0] r_fail_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_chk_issue     = 1'b0;
    w_chk_rd_idx    = '0;
    w_idx_next      = r_idx;
    w_prev_load     = 1'b0;
    w_clear         = 1'b0;
    w_result_set    = 1'b0;
    w_result_sorted = 1'b0;
    w_result_idx    = '0;
    case (r_state)
      // C_DONE lasts one cycle and behaves like idle, so a new start is
      // accepted there as well.
      C_IDLE, C_DONE: begin
        w_state_next = C_IDLE;
        if (check_start) begin
          w_clear      = 1'b1;
          w_state_next = C_FETCH0;
        end
      end
      C_FETCH0: begin
        if (!w_bus_active) begin
          w_chk_issue  = 1'b1;
          w_chk_rd_idx = '0;
          w_idx_next   = '0;
          w_state_next = C_SCAN;
        end
      end
      C_SCAN: begin
        if (!w_bus_active) begin
          if ((r_idx == '0) || (r_prev <= r_chk_word)) begin
            if (r_idx == C_LAST_IDX) begin
              w_result_set    = 1'b1;
              w_result_sorted = 1'b1;
              w_result_idx    = '0;
              w_state_next    = C_DONE;
            end else begin
              w_prev_load  = 1'b1;
              w_chk_issue  = 1'b1;
              w_chk_rd_idx = r_idx + 1'b1;
              w_idx_next   = r_idx + 1'b1;
            end
          end else begin
            w_result_set    = 1'b1;
            w_result_sorted = 1'b0;
            w_result_idx    = r_idx - 1'b1;
            w_state_next    = C_DONE;
          end
        end
      end
      default: begin
        w_state_next = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_prev     <= '0;
      r_done     <= 1'b0;
      r_sorted   <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      r_idx <= w_idx_next;
      if (w_prev_load) begin
        r_prev <= r_chk_word;
      end
      if (w_clear) begin
        r_done     <= 1'b0;
        r_sorted   <= 1'b0;
        r_fail_idx <= '0;
      end else if (w_result_set) begin
        r_done     <= 1'b1;
        r_sorted   <= w_result_sorted;
        r_fail_idx <= w_result_idx;
      end
    end
  end

  assign check_busy       = (r_state == C_FETCH0) || (r_state == C_SCAN);
  assign check_done       = r_done;
  assign check_sorted     = r_sorted;
  assign check_fail_index = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_sort_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_mem_responder
// Description : Directed self-checking bench for sort_mem_responder. A bench
//               memory model supplies the expected read data. Each expected
//               value is queued when its read is driven and popped when the
//               read data appears.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sort_mem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  check_start = 1'b0;
  logic                  check_busy;
  logic                  check_done;
  logic                  check_sorted;
  logic [DEPTH_LOG2-1:0] check_fail_index;
  logic                  access_error;

  sort_mem_responder_if bus_if ();

  sort_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus_if),
    .check_start      (check_start),
    .check_busy       (check_busy),
    .check_done       (check_done),
    .check_sorted     (check_sorted),
    .check_fail_index (check_fail_index),
    .access_error     (access_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle. Reads push their expected data from the model. The data
  // is popped and compared once the edge has passed.
  task automatic bus_cycle(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic        legal;
    logic [31:0] exp;
    legal = (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH));
    bus_if.slave_read      = rd;
    bus_if.slave_write     = wr;
    bus_if.slave_address   = addr;
    bus_if.slave_writedata = wdata;
    if (rd && !wr) exp_q.push_back(legal ? model[addr[DEPTH_LOG2+1:2]] : 32'h0);
    if (wr && legal) model[addr[DEPTH_LOG2+1:2]] = wdata;
    tick();
    bus_if.slave_read  = 1'b0;
    bus_if.slave_write = 1'b0;
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      check($sformatf("read@%08h", addr), bus_if.slave_readdata, exp);
    end
  endtask

  // Start a check and count busy cycles. Bus reads are injected at the busy
  // cycle numbers inj0..inj2 (0 = none).
  task automatic run_check(input string tag, input int exp_busy,
                           input logic exp_sorted, input int exp_idx,
                           input int inj0, input int inj1, input int inj2);
    int cnt;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    check({tag, " busy@start"}, 32'(check_busy), 32'd1);
    check({tag, " done cleared"}, 32'(check_done), 32'd0);
    cnt = 0;
    while (check_busy === 1'b1 && cnt < 5000) begin
      cnt++;
      if (cnt == inj0 || cnt == inj1 || cnt == inj2) bus_cycle(1'b1, 1'b0, 32'(cnt * 4), 32'h0);
      else tick();
    end
    check({tag, " busy cycles"}, 32'(cnt), 32'(exp_busy));
    check({tag, " done"}, 32'(check_done), 32'd1);
    check({tag, " sorted"}, 32'(check_sorted), 32'(exp_sorted));
    check({tag, " fail_index"}, 32'(check_fail_index), 32'(exp_idx));
  endtask

  initial begin
    bus_if.slave_read      = 1'b0;
    bus_if.slave_write     = 1'b0;
    bus_if.slave_address   = '0;
    bus_if.slave_writedata = '0;

    // Reset state
    repeat (2) tick();
    check("rst readdata", bus_if.slave_readdata, 32'h0);
    check("rst busy", 32'(check_busy), 32'd0);
    check("rst done", 32'(check_done), 32'd0);
    check("rst sorted", 32'(check_sorted), 32'd0);
    check("rst fail_index", 32'(check_fail_index), 32'd0);
    check("rst access_error", 32'(access_error), 32'd0);
    rst = 1'b0;

    // Write then read in the next cycle
    bus_cycle(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    check("wr/rd access_error", 32'(access_error), 32'd0);

    // Back-to-back pipelined accesses
    bus_cycle(1'b0, 1'b1, 32'h0, 32'd5);
    bus_cycle(1'b0, 1'b1, 32'h4, 32'd3);
    bus_cycle(1'b1, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b1, 1'b0, 32'h4, 32'h0);

    // Fill mem[i] = i, then read the last legal word
    for (int i = 0; i < DEPTH; i++) bus_cycle(1'b0, 1'b1, 32'(i * 4), 32'(i));
    bus_cycle(1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0);
    check("last word access_error", 32'(access_error), 32'd0);

    // Full sorted scan
    run_check("full", DEPTH + 1, 1'b1, 0, 0, 0, 0);
    repeat (3) tick();
    check("done holds", 32'(check_done), 32'd1);

    // First violation at pair (7,8), then the same with three bus stalls
    bus_cycle(1'b0, 1'b1, 32'h1C, 32'd100);
    run_check("viol", 10, 1'b0, 7, 0, 0, 0);
    run_check("viol+stall", 13, 1'b0, 7, 3, 4, 5);
    check("no error after scans", 32'(access_error), 32'd0);

    // Illegal accesses
    bus_cycle(1'b1, 1'b0, 32'h2, 32'h0);
    check("misaligned sets error", 32'(access_error), 32'd1);
    bus_cycle(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D);
    bus_cycle(1'b1, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    bus_cycle(1'b1, 1'b1, 32'h8, 32'h12345678);
    check("rd+wr readdata holds", bus_if.slave_readdata, 32'd4);
    bus_cycle(1'b1, 1'b0, 32'h8, 32'h0);
    check("error sticky", 32'(access_error), 32'd1);

    // Restore a sorted array, then reset in the middle of a check
    bus_cycle(1'b0, 1'b1, 32'h8, 32'd2);
    bus_cycle(1'b0, 1'b1, 32'h1C, 32'd7);
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    repeat (498) tick();
    check("busy before rst", 32'(check_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst readdata", bus_if.slave_readdata, 32'h0);
    check("mid rst busy", 32'(check_busy), 32'd0);
    check("mid rst done", 32'(check_done), 32'd0);
    check("mid rst sorted", 32'(check_sorted), 32'd0);
    check("mid rst fail_index", 32'(check_fail_index), 32'd0);
    check("mid rst access_error", 32'(access_error), 32'd0);
    run_check("after rst", DEPTH + 1, 1'b1, 0, 0, 0, 0);
    bus_cycle(1'b1, 1'b0, 32'h1C, 32'h0);
    bus_cycle(1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
